// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle RV32I control sequencer (FETCH/DECODE/EXEC/MEM/WB) with memory
// timeout, illegal-opcode halt and retired-instruction counter. Define MULTICYCLE_CTRL_JUMP_EN for JAL/JALR/LUI/AUIPC.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             instr_done,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef MULTICYCLE_CTRL_JUMP_EN
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
`endif

    localparam logic [1:0] SRC_PC     = 2'b00;
    localparam logic [1:0] SRC_ALUOUT = 2'b01;
    localparam logic [1:0] A_RS1      = 2'b01;
    localparam logic [1:0] A_OLD_PC   = 2'b10;
    localparam logic [1:0] B_RS2      = 2'b00;
    localparam logic [1:0] B_FOUR     = 2'b01;
    localparam logic [1:0] B_IMM      = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_BRCMP   = 2'b01;
    localparam logic [1:0] OP_FUNCT   = 2'b10;
    localparam logic [1:0] OP_PASS_B  = 2'b11;
    localparam logic [1:0] WB_ALUOUT  = 2'b00;
    localparam logic [1:0] WB_MDR     = 2'b01;
    localparam logic [1:0] WB_PC      = 2'b10;

    // Wait count at which one more unanswered request cycle is a timeout.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
    } state_e;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_ILLEGAL
    } class_e;

    state_e           state_q, state_d;
    class_e           class_q, class_d;
    class_e           op_class;
    logic [7:0]       wait_q, wait_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    always_comb begin
        case (opcode)
            OP_R:      op_class = C_R;
            OP_I:      op_class = C_I;
            OP_LOAD:   op_class = C_LOAD;
            OP_STORE:  op_class = C_STORE;
            OP_BRANCH: op_class = C_BRANCH;
`ifdef MULTICYCLE_CTRL_JUMP_EN
            OP_JAL:    op_class = C_JAL;
            OP_JALR:   op_class = C_JALR;
            OP_LUI:    op_class = C_LUI;
            OP_AUIPC:  op_class = C_AUIPC;
`endif
            default:   op_class = C_ILLEGAL;
        endcase
    end

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d       = state_q;
        class_d       = class_q;
        wait_d        = 8'd0;
        illegal_d     = illegal_q;
        bus_err_d     = bus_err_q;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = SRC_PC;
        alu_src_a     = SRC_PC;
        alu_src_b     = B_RS2;
        alu_op        = OP_ADD;
        reg_write     = 1'b0;
        wb_sel        = WB_ALUOUT;
        instr_done    = 1'b0;

        case (state_q)
            S_RST: state_d = S_FETCH;

            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = B_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_ERROR;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            S_DECODE: begin
                alu_src_a = A_OLD_PC;
                alu_src_b = B_IMM;
                class_d   = op_class;
                if (op_class == C_ILLEGAL) begin
                    state_d   = S_ERROR;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                case (class_q)
                    C_R: begin
                        alu_src_a = A_RS1;
                        alu_op    = OP_FUNCT;
                        state_d   = S_WB;
                    end
                    C_I: begin
                        alu_src_a = A_RS1;
                        alu_src_b = B_IMM;
                        alu_op    = OP_FUNCT;
                        state_d   = S_WB;
                    end
                    C_LOAD, C_STORE: begin
                        alu_src_a = A_RS1;
                        alu_src_b = B_IMM;
                        state_d   = S_MEM;
                    end
                    C_BRANCH: begin
                        alu_src_a     = A_RS1;
                        alu_op        = OP_BRCMP;
                        pc_write_cond = 1'b1;
                        pc_src        = SRC_ALUOUT;
                        instr_done    = 1'b1;
                        state_d       = S_FETCH;
                    end
`ifdef MULTICYCLE_CTRL_JUMP_EN
                    C_JAL: begin
                        pc_write   = 1'b1;
                        pc_src     = SRC_ALUOUT;
                        reg_write  = 1'b1;
                        wb_sel     = WB_PC;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    C_JALR: begin
                        alu_src_a  = A_RS1;
                        alu_src_b  = B_IMM;
                        pc_write   = 1'b1;
                        reg_write  = 1'b1;
                        wb_sel     = WB_PC;
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                    C_LUI: begin
                        alu_src_b = B_IMM;
                        alu_op    = OP_PASS_B;
                        state_d   = S_WB;
                    end
                    C_AUIPC: begin
                        alu_src_a = A_OLD_PC;
                        alu_src_b = B_IMM;
                        state_d   = S_WB;
                    end
`endif
                    default: begin
                        state_d   = S_ERROR;
                        illegal_d = 1'b1;
                    end
                endcase
            end

            S_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (class_q == C_STORE);
                if (mem_ready) begin
                    if (class_q == C_STORE) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = S_ERROR;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end

            S_WB: begin
                reg_write  = 1'b1;
                wb_sel     = (class_q == C_LOAD) ? WB_MDR : WB_ALUOUT;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end

            S_ERROR: state_d = S_ERROR;

            default: state_d = S_RST;
        endcase

        instret_d = instr_done ? instret_q + CNT_W'(1) : instret_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RST;
            class_q   <= C_ILLEGAL;
            wait_q    <= 8'd0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            instret_q <= instret_d;
        end
    end

    assign halted  = (state_q == S_ERROR);
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench; an instruction-level model expands each
// instruction into its expected per-cycle control vectors, checked against the DUT every cycle.
module tb_multicycle_control;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    typedef enum {P_IDLE, P_FETCH, P_DECODE, P_EXEC, P_MEM, P_WB, P_HALT} phase_e;
    typedef enum {K_R, K_I, K_LOAD, K_STORE, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC, K_ILL} kind_e;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       instr_done;
    } ctl_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [6:0]       opcode = 7'd0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0]       pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
    logic             reg_write, instr_done, halted, illegal, bus_err;
    logic [CNT_W-1:0] instret;

    multicycle_control #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .wb_sel(wb_sel), .instr_done(instr_done),
        .halted(halted), .illegal(illegal), .bus_err(bus_err), .instret(instret)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int start_cyc = 0;
    int last_done_cyc = -1;

    logic             chk_en = 1'b0;
    ctl_t             exp_c = '0;
    logic             exp_halted = 1'b0;
    logic             exp_illegal = 1'b0;
    logic             exp_bus_err = 1'b0;
    logic [CNT_W-1:0] exp_instret = '0;

    // Instruction-level model state.
    logic [CNT_W-1:0] instret_m = '0;
    logic             illegal_m = 1'b0;
    logic             bus_err_m = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_req",       64'(mem_req),       64'(exp_c.mem_req));
            check("mem_we",        64'(mem_we),        64'(exp_c.mem_we));
            check("iord",          64'(iord),          64'(exp_c.iord));
            check("ir_write",      64'(ir_write),      64'(exp_c.ir_write));
            check("pc_write",      64'(pc_write),      64'(exp_c.pc_write));
            check("pc_write_cond", 64'(pc_write_cond), 64'(exp_c.pc_write_cond));
            check("pc_src",        64'(pc_src),        64'(exp_c.pc_src));
            check("alu_src_a",     64'(alu_src_a),     64'(exp_c.alu_src_a));
            check("alu_src_b",     64'(alu_src_b),     64'(exp_c.alu_src_b));
            check("alu_op",        64'(alu_op),        64'(exp_c.alu_op));
            check("reg_write",     64'(reg_write),     64'(exp_c.reg_write));
            check("wb_sel",        64'(wb_sel),        64'(exp_c.wb_sel));
            check("instr_done",    64'(instr_done),    64'(exp_c.instr_done));
            check("halted",        64'(halted),        64'(exp_halted));
            check("illegal",       64'(illegal),       64'(exp_illegal));
            check("bus_err",       64'(bus_err),       64'(exp_bus_err));
            check("instret",       64'(instret),       64'(exp_instret));
            if (instr_done === 1'b1) last_done_cyc = cyc;
        end
    end

    function automatic kind_e kind_of(input logic [6:0] op);
        case (op)
            OP_R:      return K_R;
            OP_I:      return K_I;
            OP_LOAD:   return K_LOAD;
            OP_STORE:  return K_STORE;
            OP_BRANCH: return K_BR;
`ifdef MULTICYCLE_CTRL_JUMP_EN
            OP_JAL:    return K_JAL;
            OP_JALR:   return K_JALR;
            OP_LUI:    return K_LUI;
            OP_AUIPC:  return K_AUIPC;
`endif
            default:   return K_ILL;
        endcase
    endfunction

    function automatic ctl_t expect_ctl(input phase_e ph, input kind_e k, input logic rdy);
        ctl_t c = '0;
        case (ph)
            P_FETCH: begin
                c.mem_req = 1'b1; c.alu_src_b = 2'b01;
                c.ir_write = rdy; c.pc_write = rdy;
            end
            P_DECODE: begin
                c.alu_src_a = 2'b10; c.alu_src_b = 2'b10;
            end
            P_EXEC: case (k)
                K_R:     begin c.alu_src_a = 2'b01; c.alu_op = 2'b10; end
                K_I:     begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.alu_op = 2'b10; end
                K_LOAD, K_STORE: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
                K_BR:    begin c.alu_src_a = 2'b01; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
                               c.pc_src = 2'b01; c.instr_done = 1'b1; end
                K_JAL:   begin c.pc_write = 1'b1; c.pc_src = 2'b01; c.reg_write = 1'b1;
                               c.wb_sel = 2'b10; c.instr_done = 1'b1; end
                K_JALR:  begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1;
                               c.reg_write = 1'b1; c.wb_sel = 2'b10; c.instr_done = 1'b1; end
                K_LUI:   begin c.alu_src_b = 2'b10; c.alu_op = 2'b11; end
                K_AUIPC: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b10; end
                default: c = '0;
            endcase
            P_MEM: begin
                c.mem_req = 1'b1; c.iord = 1'b1; c.mem_we = (k == K_STORE);
                c.instr_done = (k == K_STORE) && rdy;
            end
            P_WB: begin
                c.reg_write = 1'b1; c.wb_sel = (k == K_LOAD) ? 2'b01 : 2'b00;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    task automatic set_exp(input phase_e ph, input kind_e k, input logic rdy);
        mem_ready   = rdy;
        exp_c       = expect_ctl(ph, k, rdy);
        exp_halted  = (ph == P_HALT);
        exp_illegal = illegal_m;
        exp_bus_err = bus_err_m;
        exp_instret = instret_m;
        chk_en      = 1'b1;
    endtask

    // One clock cycle: entered and left at posedge+1.
    task automatic step(input phase_e ph, input kind_e k, input logic rdy);
        set_exp(ph, k, rdy);
        @(posedge clk);
        #1;
        if (exp_c.instr_done) instret_m = instret_m + 1'b1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        chk_en = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        instret_m = '0;
        illegal_m = 1'b0;
        bus_err_m = 1'b0;
        step(P_IDLE, K_R, 1'b0);
    endtask

    task automatic halt_cycles(input kind_e k);
        repeat (3) step(P_HALT, k, 1'b1);
    endtask

    // Expand one instruction: fw fetch wait cycles, mw memory wait cycles.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
        kind_e k = kind_of(op);
        start_cyc = cyc;
        last_done_cyc = -1;
        opcode = ~op;
        for (int i = 0; i < fw && i < MEM_TIMEOUT; i++) step(P_FETCH, k, 1'b0);
        if (fw >= MEM_TIMEOUT) begin
            bus_err_m = 1'b1;
            halt_cycles(k);
            return;
        end
        step(P_FETCH, k, 1'b1);
        opcode = op;
        step(P_DECODE, k, 1'b1);
        if (k == K_ILL) begin
            illegal_m = 1'b1;
            halt_cycles(k);
            return;
        end
        step(P_EXEC, k, 1'b1);
        if (k == K_BR || k == K_JAL || k == K_JALR) return;
        if (k == K_LOAD || k == K_STORE) begin
            for (int i = 0; i < mw && i < MEM_TIMEOUT; i++) step(P_MEM, k, 1'b0);
            if (mw >= MEM_TIMEOUT) begin
                bus_err_m = 1'b1;
                halt_cycles(k);
                return;
            end
            step(P_MEM, k, 1'b1);
            if (k == K_STORE) return;
        end
        step(P_WB, k, 1'b1);
    endtask

    function automatic int latency();
        return last_done_cyc - start_cyc + 1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        apply_reset();
        check("reset_instret", 64'(instret), 64'd0);

        run_instr(OP_R, 0, 0);
        check("r_latency", 64'(latency()), 64'd4);
        check("r_instret", 64'(instret), 64'd1);

        run_instr(OP_I, 2, 0);
        check("i_fetchwait_latency", 64'(latency()), 64'd6);

        run_instr(OP_LOAD, 0, 3);
        check("load_memwait_latency", 64'(latency()), 64'd8);

        run_instr(OP_STORE, 1, 0);
        check("store_latency", 64'(latency()), 64'd5);

        run_instr(OP_BRANCH, 0, 0);
        check("branch_latency", 64'(latency()), 64'd3);
        check("instret_after_5", 64'(instret), 64'd5);

        // Ready on the cycle that would otherwise time out.
        run_instr(OP_R, MEM_TIMEOUT - 1, 0);
        check("ready_at_limit_latency", 64'(latency()), 64'd18);
        check("ready_at_limit_no_err", 64'(bus_err), 64'd0);
        check("instret_after_6", 64'(instret), 64'd6);

        // Reset pulsed while a store waits in MEM.
        opcode = 7'd0;
        step(P_FETCH, K_STORE, 1'b1);
        opcode = OP_STORE;
        step(P_DECODE, K_STORE, 1'b1);
        step(P_EXEC, K_STORE, 1'b1);
        set_exp(P_MEM, K_STORE, 1'b0);
        @(negedge clk);
        #1;
        check("pre_rst_mem_we", 64'(mem_we), 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_mem_we", 64'(mem_we), 64'd0);
        check("async_rst_mem_req", 64'(mem_req), 64'd0);
        check("async_rst_instret", 64'(instret), 64'd0);
        apply_reset();

        run_instr(OP_R, MEM_TIMEOUT, 0);
        check("fetch_timeout_bus_err", 64'(bus_err), 64'd1);
        check("fetch_timeout_halted", 64'(halted), 64'd1);
        apply_reset();
        check("bus_err_cleared", 64'(bus_err), 64'd0);

        run_instr(OP_R, 0, 0);
        run_instr(OP_BAD, 0, 0);
        check("bad_op_illegal", 64'(illegal), 64'd1);
        check("bad_op_instret", 64'(instret), 64'd1);
        apply_reset();
        check("illegal_cleared", 64'(illegal), 64'd0);

        run_instr(OP_LOAD, 0, MEM_TIMEOUT);
        check("mem_timeout_bus_err", 64'(bus_err), 64'd1);
        apply_reset();

`ifdef MULTICYCLE_CTRL_JUMP_EN
        run_instr(OP_JAL, 0, 0);
        check("jal_latency", 64'(latency()), 64'd3);
        run_instr(OP_JALR, 0, 0);
        check("jalr_latency", 64'(latency()), 64'd3);
        run_instr(OP_LUI, 0, 0);
        check("lui_latency", 64'(latency()), 64'd4);
        run_instr(OP_AUIPC, 0, 0);
        check("auipc_latency", 64'(latency()), 64'd4);
        check("jump_instret", 64'(instret), 64'd4);
`else
        run_instr(OP_JAL, 0, 0);
        check("jal_disabled_illegal", 64'(illegal), 64'd1);
        check("jal_disabled_halted", 64'(halted), 64'd1);
`endif
        apply_reset();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control FSM for the RV32I soft core. It replaces the single-cycle combinational opcode decoder with a sequencer that steps each instruction through FETCH, DECODE, EXEC, MEM and WB over several clocks. It also handles a valid/ready memory handshake with a timeout, an illegal-opcode halt and a retired-instruction counter. It sits between the instruction register's opcode field and the shared-memory multi-cycle datapath.

## Interface
- `MEM_TIMEOUT`, default 15: max consecutive wait cycles on one memory request before bus error; legal range 1..255.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset; one clock, asynchronous, active-high.
- `opcode` in 7: instr[6:0] from the instruction register, valid from DECODE onward.
- `mem_ready` in 1: memory accepted/completed the current request this cycle.
- `mem_req` out 1: memory request valid.
- `mem_we` out 1: write request (store).
- `iord` out 1: address select; 0 = PC, 1 = ALUOut.
- `ir_write` out 1: load instruction register.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if ALU zero (branch).
- `pc_src` out 2: 00 ALU result, 01 ALUOut.
- `alu_src_a` out 2: 00 PC, 01 rs1, 10 old PC.
- `alu_src_b` out 2: 00 rs2, 01 const 4, 10 imm.
- `alu_op` out 2: 00 add, 01 branch compare, 10 funct decode, 11 pass B.
- `reg_write` out 1: register-file write strobe.
- `wb_sel` out 2: 00 ALUOut, 01 MDR, 10 PC.
- `instr_done` out 1: one-cycle pulse per retired instruction.
- `halted` out 1: FSM in ERROR.
- `illegal` out 1: sticky; illegal opcode caused halt.
- `bus_err` out 1: sticky; memory timeout caused halt.
- `instret` out CNT_W: retired-instruction count.

## Operation
- States: RST, FETCH, DECODE, EXEC, MEM, WB, ERROR.
- Outputs are Moore from state, except strobes explicitly qualified by `mem_ready`.
- Outputs not listed for a state are 0.
- **RST:** all outputs 0. Go to FETCH at the first edge with `rst` low.
- **FETCH:** `mem_req`=1, `iord`=0, `alu_src_a`=00, `alu_src_b`=01, `alu_op`=00.
  - When `mem_ready`=1: `ir_write`=1 and `pc_write`=1, then go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE:** `alu_src_a`=10, `alu_src_b`=10, `alu_op`=00 (branch/jump target into ALUOut).
  - Latch the opcode class.
  - Unsupported opcode: go to ERROR and set `illegal`. Otherwise go to EXEC.
- **EXEC:**
  - R-type (0110011): a=01, b=00, op=10; then WB.
  - I-ALU (0010011): a=01, b=10, op=10; then WB.
  - Load/store (0000011/0100011): a=01, b=10, op=00; then MEM.
  - Branch (1100011): a=01, b=00, op=01, `pc_write_cond`=1, `pc_src`=01; then FETCH and retire.
- **MEM:** `mem_req`=1, `iord`=1, `mem_we`=1 for store.
  - On `mem_ready`: a store goes to FETCH and retires; a load goes to WB.
- **WB:** `reg_write`=1. `wb_sel`=01 for a load, otherwise 00. Then FETCH and retire.
- **ERROR:** all strobes 0, `halted`=1. Stays until `rst`.
- **Retire:** `instr_done`=1 in the final state of each instruction. `instret` increments on that edge and wraps modulo 2^CNT_W.
- **Timeout counter:** cleared whenever `mem_req` is 0 and on each `mem_ready`.
  - Increments each cycle `mem_req`=1 with `mem_ready`=0.
  - When the count reaches MEM_TIMEOUT with no ready, next state is ERROR and `bus_err` is set.
  - `mem_ready` arriving in that same cycle wins: no error.
- **Reset:** `rst` asserted mid-instruction aborts it immediately.
  - Enters RST and clears the counters, `illegal`, `bus_err` and `instret`.
  - No partial strobe survives.

## Timing
- Latencies in cycles with zero-wait memory (`mem_ready`=1 on the first request cycle):
  - Branch: 3. Store: 4. R/I-ALU: 4. Load: 5. JAL/JALR: 3. LUI/AUIPC: 4.
- Each memory wait cycle adds exactly 1.
- `mem_req` holds steady until the cycle `mem_ready` is sampled high.
- `ir_write` and `reg_write` are single-cycle.
- `instr_done` is asserted in the cycle before FETCH.
- `halted` rises the cycle after the faulting state.

## Configuration
- Macro: `MULTICYCLE_CTRL_JUMP_EN`.
- **Defined:** JAL, JALR, LUI and AUIPC are legal.
  - JAL (1101111) EXEC: `pc_write`=1, `pc_src`=01, `reg_write`=1, `wb_sel`=10; then FETCH and retire.
  - JALR (1100111) EXEC: a=01, b=10, op=00, `pc_write`=1, `pc_src`=00, `reg_write`=1, `wb_sel`=10; then FETCH and retire.
  - LUI (0110111) EXEC: b=10, op=11; then WB.
  - AUIPC (0010111) EXEC: a=10, b=10, op=00; then WB.
- **Undefined:** these four opcodes take DECODE to ERROR with `illegal`=1.

## Test plan
- Zero-wait R-type (0110011) after reset release: states FETCH, DECODE, EXEC, WB. `reg_write`=1 only in cycle 4, `instr_done`=1 in cycle 4, `instret`=1.
- Load with `mem_ready` held low for 3 cycles in MEM: total 8 cycles. `wb_sel`=01 in WB. `mem_req` stays high for the 4 MEM cycles.
- Fetch with `mem_ready` never asserted: ERROR entered after 15 wait cycles. `bus_err`=1, `halted`=1, every strobe 0 thereafter. Ready on the 15th wait cycle instead: no error.
- Opcode 1111111: `illegal`=1 after DECODE. `instret` unchanged. Only `rst` recovers, after which `illegal`=0.
- `rst` pulsed during MEM of a store with `mem_we`=1: `mem_we` drops to 0 asynchronously, FSM in RST, `instret`=0.
- With the macro defined, JAL: 3 cycles, `pc_write`=1, `wb_sel`=10 in EXEC. Without the macro, same opcode: ERROR with `illegal`=1.
